// File: rtl/count_driver_pkg.sv
// Shared types and constants for the count_driver stimulus sequencer.
package count_driver_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PH0   = 3'd2,
    PH1   = 3'd3,
    FIN   = 3'd4
  } state_e;

  localparam int unsigned SLT_DIV  = 4;
  localparam int unsigned SUB_W    = $clog2(SLT_DIV);
  localparam int unsigned MIRROR_W = 64;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SLT_DIV - 1);

  // Registered output bundle; ph marks the states where En may be asserted.
  typedef struct packed {
    logic clr;
    logic ph;
    logic slt;
    logic busy;
    logic done;
  } drv_out_t;

  function automatic drv_out_t state_outputs(input state_e s);
    drv_out_t o;
    o = '0;
    case (s)
      CLEAR: begin
        o.clr  = 1'b1;
        o.busy = 1'b1;
      end
      PH0: begin
        o.ph   = 1'b1;
        o.busy = 1'b1;
      end
      PH1: begin
        o.ph   = 1'b1;
        o.slt  = 1'b1;
        o.busy = 1'b1;
      end
      FIN:     o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/count_driver_if.sv
// Sequencer control/stimulus bundle between the requester and count_driver.
interface count_driver_if
  import count_driver_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);

  logic                Start;
  logic [WIDTH-1:0]    Target0;
  logic [WIDTH-1:0]    Target1;
  logic                Pause;
  logic                ClrOut;
  logic                En;
  logic                Slt;
  logic                Busy;
  logic                Done;
  logic [MIRROR_W-1:0] Mirror0;
  logic [MIRROR_W-1:0] Mirror1;

  modport master (
    output Start, Target0, Target1, Pause,
    input  ClrOut, En, Slt, Busy, Done, Mirror0, Mirror1
  );

  modport slave (
    input  Start, Target0, Target1, Pause,
    output ClrOut, En, Slt, Busy, Done, Mirror0, Mirror1
  );

endinterface

// File: rtl/count_driver_mirror.sv
// Shadow model of the two-channel event counter fed by count_driver's stimulus.
module count_driver_mirror
  import count_driver_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                inc0_i,
  input  logic                step1_i,
  output logic [MIRROR_W-1:0] mirror0_o,
  output logic [MIRROR_W-1:0] mirror1_o
);

  logic [SUB_W-1:0]    sub_q;
  logic [MIRROR_W-1:0] m0_q;
  logic [MIRROR_W-1:0] m1_q;

  // Channel 1 advances once per SLT_DIV select-1 enables, like the real counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q <= '0;
      m0_q  <= '0;
      m1_q  <= '0;
    end else if (clr_i) begin
      sub_q <= '0;
      m0_q  <= '0;
      m1_q  <= '0;
    end else begin
      if (inc0_i) begin
        m0_q <= m0_q + MIRROR_W'(1);
      end
      if (step1_i) begin
        sub_q <= sub_q + SUB_W'(1);
        if (sub_q == SUB_LAST) begin
          m1_q <= m1_q + MIRROR_W'(1);
        end
      end
    end
  end

  assign mirror0_o = m0_q;
  assign mirror1_o = m1_q;

endmodule

// File: rtl/count_driver.sv
// Clears the event counter, then issues enough En/Slt cycles to reach Target0/Target1.
// Optional counter shadow registers are built when COUNT_DRIVER_MIRROR_EN is defined.
module count_driver
  import count_driver_pkg::*;
#(
  parameter int unsigned WIDTH = 16
)
(
  input  logic          Clk,
  input  logic          Reset,
  count_driver_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem0_q, rem0_d;
  logic [WIDTH-1:0] rem1_q, rem1_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  drv_out_t         out_q;
  logic             en_c;

  // En is the only output allowed to follow Pause within the cycle.
  assign en_c = out_q.ph & ~bus.Pause;

  // Next-state and remaining-count update.
  always_comb begin
    state_d = state_q;
    rem0_d  = rem0_q;
    rem1_d  = rem1_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = CLEAR;
          rem0_d  = bus.Target0;
          rem1_d  = bus.Target1;
          sub_d   = '0;
        end
      end
      CLEAR: begin
        if (rem0_q != '0) begin
          state_d = PH0;
        end else if (rem1_q != '0) begin
          state_d = PH1;
        end else begin
          state_d = FIN;
        end
      end
      PH0: begin
        if (en_c) begin
          rem0_d = rem0_q - ONE;
          if (rem0_q == ONE) begin
            state_d = (rem1_q != '0) ? PH1 : FIN;
          end
        end
      end
      PH1: begin
        if (en_c) begin
          sub_d = sub_q + SUB_W'(1);
          if (sub_q == SUB_LAST) begin
            rem1_d = rem1_q - ONE;
            if (rem1_q == ONE) begin
              state_d = FIN;
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered alongside the state they decode.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rem0_q  <= '0;
      rem1_q  <= '0;
      sub_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rem0_q  <= rem0_d;
      rem1_q  <= rem1_d;
      sub_q   <= sub_d;
      out_q   <= state_outputs(state_d);
    end
  end

  assign bus.ClrOut = out_q.clr;
  assign bus.En     = en_c;
  assign bus.Slt    = out_q.slt;
  assign bus.Busy   = out_q.busy;
  assign bus.Done   = out_q.done;

`ifdef COUNT_DRIVER_MIRROR_EN
  logic [MIRROR_W-1:0] mirror0;
  logic [MIRROR_W-1:0] mirror1;

  count_driver_mirror u_mirror (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .clr_i     (out_q.clr),
    .inc0_i    (en_c & ~out_q.slt),
    .step1_i   (en_c & out_q.slt),
    .mirror0_o (mirror0),
    .mirror1_o (mirror1)
  );

  assign bus.Mirror0 = mirror0;
  assign bus.Mirror1 = mirror1;
`else
  assign bus.Mirror0 = '0;
  assign bus.Mirror1 = '0;
`endif

endmodule
